fifo_burst_seq: RTL

Sequencer that drives the 4-lane FIFO write/read ports through one burst.
- Fill phase: writes an incrementing 4-bit pattern on din_a..din_d, gated by writable.
- Drain phase: reads back the same number of words, gated by readable.
- Optional compare of read data against the expected pattern.
- Sits between the FIFO top and the board-level start/status logic, replacing the hand-sequenced we/re stimulus.

---
 rtl/fifo_burst_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fifo_burst_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : fifo_burst_seq                                                 |
// | Purpose  : Fills the 4-lane FIFO with one incrementing burst and drains   |
// |            it again. Define FIFO_BURST_CHECK_EN to build the read-data    |
// |            compare and the saturating mismatch counter.                   |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module fifo_burst_seq #(
  parameter int BURST_LEN = 8,
  parameter int READ_LAT  = 1,
  parameter int ERR_W     = 8
) (
  input  logic             write_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             writable,
  input  logic             readable,
  input  logic [3:0]       dout,
  output logic             we,
  output logic             re,
  output logic             din_a,
  output logic             din_b,
  output logic             din_c,
  output logic             din_d,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_DRAIN = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] c_burst_len  = 8'(BURST_LEN);
  localparam logic [2:0] c_flush_init = 3'(READ_LAT - 1);

  state_t     r_state;
  logic [7:0] r_wr_cnt;
  logic [7:0] r_rd_cnt;
  logic [2:0] r_flush_cnt;
  logic [3:0] r_din;
  logic       r_we;
  logic       r_re;
  logic       r_busy;
  logic       r_done;
  logic [7:0] w_wr_next;
  logic [7:0] w_rd_next;

  assign w_wr_next = r_wr_cnt + 8'd1;
  assign w_rd_next = r_rd_cnt + 8'd1;

  always_ff @(posedge write_clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_cnt    <= 8'd0;
      r_rd_cnt    <= 8'd0;
      r_flush_cnt <= 3'd0;
      r_din       <= 4'd0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_re   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_FILL;
            r_busy   <= 1'b1;
            r_wr_cnt <= 8'd0;
            r_rd_cnt <= 8'd0;
          end
        end
        S_FILL: begin
          // The pattern is the post-increment count, so the first word is 1.
          if (r_wr_cnt == c_burst_len) begin
            r_state <= S_DRAIN;
          end else if (writable) begin
            r_we     <= 1'b1;
            r_din    <= w_wr_next[3:0];
            r_wr_cnt <= w_wr_next;
          end
        end
        S_DRAIN: begin
          if (r_rd_cnt == c_burst_len) begin
            r_state     <= S_FLUSH;
            r_flush_cnt <= c_flush_init;
          end else if (readable) begin
            r_re     <= 1'b1;
            r_rd_cnt <= w_rd_next;
          end
        end
        S_FLUSH: begin
          // Lands on the same edge that compares the last read word.
          if (r_flush_cnt == 3'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign we    = r_we;
  assign re    = r_re;
  assign din_a = r_din[0];
  assign din_b = r_din[1];
  assign din_c = r_din[2];
  assign din_d = r_din[3];
  assign busy  = r_busy;
  assign done  = r_done;

`ifdef FIFO_BURST_CHECK_EN
  // Stage i holds the expected word for a read issued i cycles ago; while re
  // is high r_rd_cnt already equals that read's index.
  logic             r_pipe_vld [1:READ_LAT];
  logic [3:0]       r_pipe_exp [1:READ_LAT];
  logic [ERR_W-1:0] r_err_cnt;

  always_ff @(posedge write_clk) begin
    if (rst) begin
      for (int i = 1; i <= READ_LAT; i++) begin
        r_pipe_vld[i] <= 1'b0;
        r_pipe_exp[i] <= 4'd0;
      end
      r_err_cnt <= '0;
    end else begin
      r_pipe_vld[1] <= r_re;
      r_pipe_exp[1] <= r_rd_cnt[3:0];
      for (int i = 2; i <= READ_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_exp[i] <= r_pipe_exp[i-1];
      end
      if (r_state == S_IDLE && start) begin
        r_err_cnt <= '0;
      end else if (r_pipe_vld[READ_LAT] && (dout != r_pipe_exp[READ_LAT])
                   && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused_dout;
  assign w_unused_dout = ^dout;
  assign err_cnt       = '0;
`endif

endmodule
`default_nettype wire
